// File: rtl/fetch_seq_if.sv
// Port bundle for the minicpu program sequencer: run control, ROM read port,
// issued instruction and the debug ROM reader.
interface fetch_seq_if;
   logic        run;
   logic        step;
   logic        halt_req;
   logic        carry;
   logic [3:0]  rom_addr;
   logic [11:0] rom_data;
   logic [11:0] instr;
   logic        instr_valid;
   logic [3:0]  pc;
   logic [1:0]  state;
   logic        spin;
   logic        dbg_req;
   logic [3:0]  dbg_addr;
   logic [11:0] dbg_data;
   logic        dbg_ack;

   modport master (
      input  run, step, halt_req, carry, rom_data, dbg_req, dbg_addr,
      output rom_addr, instr, instr_valid, pc, state, spin, dbg_data, dbg_ack
   );

   modport slave (
      output run, step, halt_req, carry, rom_data, dbg_req, dbg_addr,
      input  rom_addr, instr, instr_valid, pc, state, spin, dbg_data, dbg_ack
   );
endinterface

// File: rtl/fetch_seq.sv
// Program sequencer for the 4-bit minicpu: PC, fetch/exec FSM, JMP/JNC
// resolution, run/halt/step control and a debug reader sharing the ROM port.
module fetch_seq #(
   parameter logic [3:0] RESET_PC = 4'h0,
   parameter bit         AUTO_RUN = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   fetch_seq_if.master bus
);

   typedef enum logic [1:0] {
      ST_HALT  = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10
   } state_t;

   state_t      state_r, state_nx_s;
   logic [3:0]  pc_r, pc_nx_s;
   logic [11:0] instr_r;
   logic        valid_r;
   logic        spin_r, spin_nx_s;
   logic        step_mode_r, step_mode_nx_s;
   logic        halt_pend_r;
   logic        dbg_ack_r;
   logic [11:0] dbg_data_r;
   logic        grant_s;
   logic        taken_s;
   logic [3:0]  target_s;

   // Jump decode: JMP always taken, JNC taken on clear carry.
   always_comb begin
      taken_s = 1'b0;
      case (instr_r[11:8])
         4'hF:    taken_s = 1'b1;
         4'hE:    taken_s = ~bus.carry;
         default: taken_s = 1'b0;
      endcase
   end

   // Next program counter for the instruction in EXEC.
   always_comb begin
      if (taken_s) begin
         target_s = instr_r[3:0];
      end else begin
         target_s = pc_r + 4'd1;
      end
   end

   // The debug reader borrows the ROM port whenever the CPU is not fetching.
   always_comb begin
      grant_s = (state_r != ST_FETCH) && bus.dbg_req && !dbg_ack_r;
      if (grant_s) begin
         bus.rom_addr = bus.dbg_addr;
      end else begin
         bus.rom_addr = pc_r;
      end
   end

   // FSM next-state, PC and spin update.
   always_comb begin
      state_nx_s     = state_r;
      step_mode_nx_s = step_mode_r;
      pc_nx_s        = pc_r;
      spin_nx_s      = spin_r;
      case (state_r)
         ST_HALT: begin
            // run wins over step, but a concurrent halt_req holds the start
            if (bus.run) begin
               if (!bus.halt_req) begin
                  state_nx_s     = ST_FETCH;
                  step_mode_nx_s = 1'b0;
               end else begin
                  state_nx_s = ST_HALT;
               end
            end else if (bus.step) begin
               state_nx_s     = ST_FETCH;
               step_mode_nx_s = 1'b1;
            end else begin
               state_nx_s = ST_HALT;
            end
         end
         ST_FETCH: begin
            state_nx_s = ST_EXEC;
         end
         ST_EXEC: begin
            pc_nx_s   = target_s;
            spin_nx_s = taken_s && (instr_r[3:0] == pc_r);
            if (step_mode_r || halt_pend_r || bus.halt_req || !bus.run) begin
               state_nx_s = ST_HALT;
            end else begin
               state_nx_s = ST_FETCH;
            end
         end
         default: begin
            state_nx_s = ST_HALT;
         end
      endcase
   end

   // State, instruction latch and debug read registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= AUTO_RUN ? ST_FETCH : ST_HALT;
         step_mode_r <= 1'b0;
         pc_r        <= RESET_PC;
         instr_r     <= 12'h000;
         valid_r     <= 1'b0;
         spin_r      <= 1'b0;
         halt_pend_r <= 1'b0;
         dbg_ack_r   <= 1'b0;
         dbg_data_r  <= 12'h000;
      end else begin
         state_r     <= state_nx_s;
         step_mode_r <= step_mode_nx_s;
         pc_r        <= pc_nx_s;
         spin_r      <= spin_nx_s;
         valid_r     <= (state_nx_s == ST_EXEC);
         halt_pend_r <= (state_r == ST_FETCH) && bus.halt_req;
         if (state_r == ST_FETCH) begin
            instr_r <= bus.rom_data;
         end
         dbg_ack_r <= grant_s;
         if (grant_s) begin
            dbg_data_r <= bus.rom_data;
         end
      end
   end

   assign bus.instr       = instr_r;
   assign bus.instr_valid = valid_r;
   assign bus.pc          = pc_r;
   assign bus.state       = state_r;
   assign bus.spin        = spin_r;
   assign bus.dbg_data    = dbg_data_r;
   assign bus.dbg_ack     = dbg_ack_r;

endmodule
